// File: rtl/bus_mem_responder_pkg.sv
// rtl/bus_mem_responder_pkg.sv - shared types and bus constants for the memory responder
package bus_mem_responder_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int BE_WIDTH    = 4;
    localparam int BURST_WIDTH = 8;
    localparam int COUNT_WIDTH = BURST_WIDTH + 1;

    // Value driven onto the wired-OR bus whenever this target has no read beat
    localparam logic [DATA_WIDTH-1:0] BUS_IDLE = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_READ    = 3'd4,
        ST_RD_END  = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

endpackage

// File: rtl/bus_mem_responder_ram.sv
// rtl/bus_mem_responder_ram.sv - single-port word RAM with byte write enables and registered read
module bus_mem_responder_ram
    import bus_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [BE_WIDTH-1:0]   i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write and one-cycle synchronous read; contents are never reset
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - burst-capable memory target on the shared system bus
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 2,
    parameter int          WRITE_WAIT   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   begin_transaction_in,
    input  logic                   read_n_write_in,
    input  logic [BURST_WIDTH-1:0] burst_size_in,
    input  logic [BE_WIDTH-1:0]    byte_enables_in,
    input  logic [DATA_WIDTH-1:0]  address_data_in,
    input  logic                   data_valid_in,
    input  logic                   end_transaction_in,
    output logic [DATA_WIDTH-1:0]  address_data_out,
    output logic                   data_valid_out,
    output logic                   end_transaction_out,
    output logic                   busy_out,
    output logic                   error_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Wait-counter reload values: the read wait state lasts READ_LATENCY-1 cycles,
    // the write wait state lasts WRITE_WAIT cycles, and the counter counts down to 0.
    localparam logic [7:0] RD_WAIT_INIT = 8'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
    localparam logic [7:0] WR_WAIT_INIT = 8'((WRITE_WAIT >= 1) ? (WRITE_WAIT - 1) : 0);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [BURST_WIDTH-1:0]  r_burst;
    logic [BE_WIDTH-1:0]     r_be;
    logic [7:0]              r_wait;
    logic                    r_dv;
    logic                    r_eot;
    logic                    r_busy;
    logic                    r_err;

    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_selected;
    logic [32:0]             w_last_word;
    logic                    w_bad;
    logic                    w_beat_extra;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_word       = address_data_in[ADDR_WIDTH+1:2];
    assign w_selected   = (address_data_in[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
    assign w_last_word  = 33'(w_word) + 33'(burst_size_in);
    assign w_bad        = (w_last_word > 33'(DEPTH - 1)) || (address_data_in[1:0] != 2'b00);

    // A beat arriving after burst+1 beats were already accepted is an overrun
    assign w_beat_extra = (r_count > {1'b0, r_burst});
    assign w_we         = (r_state == ST_WRITE) && data_valid_in && !w_beat_extra;

    // While idle the RAM reads the address being decoded so a one-cycle read
    // latency can still be met; afterwards r_addr is the next word to access.
    assign w_ram_addr   = (r_state == ST_IDLE) ? w_word : r_addr;

    bus_mem_responder_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_addr  (w_ram_addr),
        .i_wdata (address_data_in),
        .o_rdata (w_rdata)
    );

    // Transaction FSM with registered bus outputs and beat/wait counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_burst <= '0;
            r_be    <= '0;
            r_wait  <= '0;
            r_dv    <= 1'b0;
            r_eot   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_eot <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (begin_transaction_in && w_selected) begin
                        r_burst <= burst_size_in;
                        r_be    <= byte_enables_in;
                        r_count <= '0;
                        if (w_bad) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                            r_eot   <= 1'b1;
                        end else if (read_n_write_in) begin
                            if (READ_LATENCY <= 1) begin
                                r_state <= ST_READ;
                                r_dv    <= 1'b1;
                                r_addr  <= w_word + 1'b1;
                            end else begin
                                r_state <= ST_RD_WAIT;
                                r_wait  <= RD_WAIT_INIT;
                                r_addr  <= w_word;
                            end
                        end else begin
                            r_addr <= w_word;
                            if (WRITE_WAIT == 0) begin
                                r_state <= ST_WRITE;
                            end else begin
                                r_state <= ST_WR_WAIT;
                                r_busy  <= 1'b1;
                                r_wait  <= WR_WAIT_INIT;
                            end
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (end_transaction_in) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wait == 8'd0) begin
                        r_state <= ST_WRITE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (data_valid_in && w_beat_extra) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                        r_eot   <= 1'b1;
                    end else begin
                        if (w_we) begin
                            r_addr  <= r_addr + 1'b1;
                            r_count <= r_count + 1'b1;
                        end
                        if (end_transaction_in) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (end_transaction_in) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait == 8'd0) begin
                        r_state <= ST_READ;
                        r_dv    <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ST_READ: begin
                    // Fetch the following word every cycle; an overfetch past the
                    // last beat is harmless because data_valid_out gates it off.
                    r_addr <= r_addr + 1'b1;
                    if (end_transaction_in) begin
                        r_state <= ST_IDLE;
                        r_dv    <= 1'b0;
                    end else if (r_count == {1'b0, r_burst}) begin
                        r_state <= ST_RD_END;
                        r_dv    <= 1'b0;
                        r_eot   <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_RD_END: begin
                    r_state <= ST_IDLE;
                end
                ST_ERROR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dv    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Flag an initiator that starts a new transaction before this one finished
    always_ff @(posedge clock) begin
        if (!reset && begin_transaction_in) begin
            assert (r_state == ST_IDLE);
        end
    end

    // The RAM read register is the data register; gating keeps the wired-OR bus at idle
    assign address_data_out    = r_dv ? w_rdata : BUS_IDLE;
    assign data_valid_out      = r_dv;
    assign end_transaction_out = r_eot;
    assign busy_out            = r_busy;
    assign error_out           = r_err;

endmodule
